// File: rtl/cpu_pkg.sv
// cpu_pkg: widths shared with the CPU register file and the state type of the
// register-file self-checker.
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } selfcheck_state_t;

    // Table index width; a one-entry table still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/rf_selfcheck_if.sv
// rf_selfcheck_if: table programming, start/status and register-file read port
// of the self-checker. master = checker side, slave = CPU / test side.
interface rf_selfcheck_if
    import cpu_pkg::*;
#(
    parameter int DATA_W     = CPU_DATA_W,
    parameter int ADDR_W     = CPU_ADDR_W,
    parameter int NUM_CHECKS = 8,
    parameter int WAIT_W     = 16
);
    localparam int IDX_W = idx_width(NUM_CHECKS);
    localparam int CNT_W = $clog2(NUM_CHECKS + 1);

    logic              exp_we;
    logic [IDX_W-1:0]  exp_idx;
    logic [ADDR_W-1:0] exp_reg;
    logic [DATA_W-1:0] exp_val;
    logic              exp_valid;
    logic              start;
    logic [WAIT_W-1:0] wait_cycles;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  fail_count;
    logic [IDX_W-1:0]  first_fail_idx;
    logic [DATA_W-1:0] first_fail_val;

    modport master (
        input  exp_we, exp_idx, exp_reg, exp_val, exp_valid, start, wait_cycles, rd_data,
        output rd_en, rd_addr, busy, done, pass, fail_count, first_fail_idx, first_fail_val
    );

    modport slave (
        output exp_we, exp_idx, exp_reg, exp_val, exp_valid, start, wait_cycles, rd_data,
        input  rd_en, rd_addr, busy, done, pass, fail_count, first_fail_idx, first_fail_val
    );

endinterface

// File: rtl/selfcheck_table.sv
// selfcheck_table: NUM_CHECKS-entry (register, expected value, valid) array with
// one write port and one combinational indexed read port.
module selfcheck_table #(
    parameter int NUM_CHECKS = 8,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int IDX_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [ADDR_W-1:0] wreg,
    input  logic [DATA_W-1:0] wval,
    input  logic              wvalid,
    input  logic [IDX_W-1:0]  ridx,
    output logic [ADDR_W-1:0] rreg,
    output logic [DATA_W-1:0] rval,
    output logic              rvalid
);

    logic [ADDR_W-1:0] reg_r   [NUM_CHECKS];
    logic [DATA_W-1:0] val_r   [NUM_CHECKS];
    logic              valid_r [NUM_CHECKS];

    // Entry storage; reset invalidates the whole table.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                reg_r[i]   <= {ADDR_W{1'b0}};
                val_r[i]   <= {DATA_W{1'b0}};
                valid_r[i] <= 1'b0;
            end
        end else if (we) begin
            reg_r[widx]   <= wreg;
            val_r[widx]   <= wval;
            valid_r[widx] <= wvalid;
        end
    end

    assign rreg   = reg_r[ridx];
    assign rval   = val_r[ridx];
    assign rvalid = valid_r[ridx];

endmodule

// File: rtl/rf_selfcheck.sv
// rf_selfcheck: waits, scans a table of expected register values through a
// one-cycle-latency read port and reports pass/fail. Option: RF_SELFCHECK_STOP_ON_FAIL_EN.
module rf_selfcheck
    import cpu_pkg::*;
#(
    parameter int DATA_W     = CPU_DATA_W,
    parameter int ADDR_W     = CPU_ADDR_W,
    parameter int NUM_CHECKS = 8,
    parameter int WAIT_W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    rf_selfcheck_if.master bus
);

    localparam int IDX_W = idx_width(NUM_CHECKS);
    localparam int CNT_W = $clog2(NUM_CHECKS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
`ifdef RF_SELFCHECK_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    selfcheck_state_t  state_r, state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [IDX_W-1:0]  scan_idx_r, scan_idx_nxt_s;
    logic              rd_en_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [IDX_W-1:0]  iss_idx_r, cmp_idx_r;
    logic [DATA_W-1:0] iss_exp_r, cmp_exp_r;
    logic              cmp_vld_r;
    logic              busy_r, done_r, pass_r;
    logic [CNT_W-1:0]  fail_cnt_r, fail_cnt_nxt_s;
    logic [IDX_W-1:0]  ff_idx_r;
    logic [DATA_W-1:0] ff_val_r;
    logic              idle_s, start_s, tbl_we_s, mismatch_s, issue_s;
    logic [ADDR_W-1:0] tbl_reg_s;
    logic [DATA_W-1:0] tbl_val_s;
    logic              tbl_valid_s;

    // start and table writes are only honoured while no check is running
    assign idle_s   = (state_r == S_IDLE) || (state_r == S_DONE);
    assign start_s  = idle_s && bus.start;
    assign tbl_we_s = idle_s && bus.exp_we;

    selfcheck_table #(
        .NUM_CHECKS (NUM_CHECKS),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W)
    ) u_table (
        .clk    (clk),
        .rst    (rst),
        .we     (tbl_we_s),
        .widx   (bus.exp_idx),
        .wreg   (bus.exp_reg),
        .wval   (bus.exp_val),
        .wvalid (bus.exp_valid),
        .ridx   (scan_idx_nxt_s),
        .rreg   (tbl_reg_s),
        .rval   (tbl_val_s),
        .rvalid (tbl_valid_s)
    );

    // Compare stage result, next state and next scan index.
    always_comb begin
        state_nxt_s    = state_r;
        scan_idx_nxt_s = {IDX_W{1'b0}};
        mismatch_s     = 1'b0;
        fail_cnt_nxt_s = fail_cnt_r;
        if (((state_r == S_SCAN) || (state_r == S_DRAIN)) && cmp_vld_r &&
            (bus.rd_data != cmp_exp_r)) begin
            mismatch_s     = 1'b1;
            fail_cnt_nxt_s = fail_cnt_r + CNT_W'(1'b1);
        end else begin
            mismatch_s     = 1'b0;
        end
        case (state_r)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_nxt_s = (bus.wait_cycles == {WAIT_W{1'b0}}) ? S_SCAN : S_WAIT;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_WAIT: begin
                if (wait_cnt_r == {WAIT_W{1'b0}}) begin
                    state_nxt_s = S_SCAN;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_SCAN: begin
                if (STOP_ON_FAIL && mismatch_s) begin
                    state_nxt_s = S_DONE;
                end else if (scan_idx_r == LAST_IDX) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s    = S_SCAN;
                    scan_idx_nxt_s = scan_idx_r + IDX_W'(1'b1);
                end
            end
            S_DRAIN: state_nxt_s = S_DONE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // The read for an entry is launched on the edge that makes it the current index.
    assign issue_s = (state_nxt_s == S_SCAN) && tbl_valid_s;

    // State register, wait counter and read-issue registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            scan_idx_r <= {IDX_W{1'b0}};
            wait_cnt_r <= {WAIT_W{1'b0}};
            rd_en_r    <= 1'b0;
            rd_addr_r  <= {ADDR_W{1'b0}};
            iss_idx_r  <= {IDX_W{1'b0}};
            iss_exp_r  <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            scan_idx_r <= scan_idx_nxt_s;
            if (start_s) begin
                wait_cnt_r <= bus.wait_cycles - WAIT_W'(1'b1);
            end else if (state_r == S_WAIT) begin
                wait_cnt_r <= wait_cnt_r - WAIT_W'(1'b1);
            end
            rd_en_r <= issue_s;
            if (issue_s) begin
                rd_addr_r <= tbl_reg_s;
                iss_idx_r <= scan_idx_nxt_s;
                iss_exp_r <= tbl_val_s;
            end
        end
    end

    // Compare pipeline and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_vld_r  <= 1'b0;
            cmp_idx_r  <= {IDX_W{1'b0}};
            cmp_exp_r  <= {DATA_W{1'b0}};
            fail_cnt_r <= {CNT_W{1'b0}};
            ff_idx_r   <= {IDX_W{1'b0}};
            ff_val_r   <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
        end else begin
            cmp_vld_r <= rd_en_r && !start_s;
            cmp_idx_r <= iss_idx_r;
            cmp_exp_r <= iss_exp_r;
            if (start_s) begin
                fail_cnt_r <= {CNT_W{1'b0}};
                ff_idx_r   <= {IDX_W{1'b0}};
                ff_val_r   <= {DATA_W{1'b0}};
            end else if (mismatch_s) begin
                fail_cnt_r <= fail_cnt_nxt_s;
                if (fail_cnt_r == {CNT_W{1'b0}}) begin
                    ff_idx_r <= cmp_idx_r;
                    ff_val_r <= bus.rd_data;
                end
            end
            busy_r <= (state_nxt_s == S_WAIT) || (state_nxt_s == S_SCAN) ||
                      (state_nxt_s == S_DRAIN);
            done_r <= (state_nxt_s == S_DONE);
            pass_r <= (state_nxt_s == S_DONE) && (fail_cnt_nxt_s == {CNT_W{1'b0}});
        end
    end

    assign bus.rd_en          = rd_en_r;
    assign bus.rd_addr        = rd_addr_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.pass           = pass_r;
    assign bus.fail_count     = fail_cnt_r;
    assign bus.first_fail_idx = ff_idx_r;
    assign bus.first_fail_val = ff_val_r;

endmodule

// File: tb/tb_rf_selfcheck.sv
// tb_rf_selfcheck: randomized and directed scans against a table/RF reference
// model; a monitor checks every read and every completion from scoreboard queues.
module tb_rf_selfcheck;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int WW = 16;
`ifdef RF_SELFCHECK_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        int unsigned   start_cyc;
        int unsigned   lat;
        logic          pass;
        int unsigned   fcnt;
        int unsigned   fidx;
        logic [DW-1:0] fval;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int unsigned cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit abort_mode = 1'b0;

    exp_t          exp_q[$];
    int unsigned   rd_q[$];
    exp_t          last_e;

    logic [DW-1:0] rf      [32];
    bit            m_valid [N];
    int unsigned   m_reg   [N];
    logic [DW-1:0] m_val   [N];

    rf_selfcheck_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_CHECKS(N), .WAIT_W(WW)) bus ();

    rf_selfcheck #(.DATA_W(DW), .ADDR_W(AW), .NUM_CHECKS(N), .WAIT_W(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Register file: read data appears the cycle after rd_en.
    initial forever begin
        @(posedge clk);
        if (bus.rd_en) bus.rd_data <= rf[bus.rd_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event with value %0h, expected none (cycle %0d)", name, act, cyc);
    endtask

    // Monitor: every read against the expected address list, every completion
    // against the expected result record.
    initial begin
        bit done_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0;
            end else begin
                if (bus.rd_en && !abort_mode) begin
                    if (rd_q.size() == 0) fail_now("unexpected_read", 64'(bus.rd_addr));
                    else chk("rd_addr", 64'(bus.rd_addr), 64'(rd_q.pop_front()));
                end
                if (bus.done && !done_prev) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_done", 64'(bus.fail_count));
                    end else begin
                        e = exp_q.pop_front();
                        chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
                        chk("pass", 64'(bus.pass), 64'(e.pass));
                        chk("fail_count", 64'(bus.fail_count), 64'(e.fcnt));
                        chk("first_fail_idx", 64'(bus.first_fail_idx), 64'(e.fidx));
                        chk("first_fail_val", 64'(bus.first_fail_val), 64'(e.fval));
                        chk("busy_at_done", 64'(bus.busy), 64'd0);
                    end
                end
                done_prev = bus.done;
            end
        end
    end

    task automatic wr(input int unsigned idx, input int unsigned r, input logic [DW-1:0] v,
                      input bit vld);
        @(posedge clk); #1;
        bus.exp_we    = 1'b1;
        bus.exp_idx   = 3'(idx);
        bus.exp_reg   = 5'(r);
        bus.exp_val   = v;
        bus.exp_valid = vld;
        @(posedge clk); #1;
        bus.exp_we    = 1'b0;
        m_valid[idx] = vld;
        m_reg[idx]   = r;
        m_val[idx]   = v;
    endtask

    // Reference: valid entries are read in index order; with stop-on-fail the
    // read already in flight behind the first mismatch is the last one.
    task automatic run_check(input int unsigned w, input bit poke_busy);
        exp_t e;
        int k_first = -1;
        int nf = 0;
        e.fval = '0;
        for (int i = 0; i < N; i++) begin
            if (STOP && k_first >= 0 && i > k_first + 1) break;
            if (m_valid[i]) begin
                rd_q.push_back(m_reg[i]);
                if (rf[m_reg[i]] != m_val[i] && !(STOP && k_first >= 0)) begin
                    if (k_first < 0) begin
                        k_first = i;
                        e.fval  = rf[m_reg[i]];
                    end
                    nf++;
                end
            end
        end
        e.lat  = (STOP && k_first >= 0) ? w + k_first + 3 : w + N + 2;
        e.pass = (nf == 0);
        e.fcnt = nf;
        e.fidx = (k_first < 0) ? 0 : k_first;
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.wait_cycles = 16'(w);
        e.start_cyc     = cyc;
        exp_q.push_back(e);
        last_e = e;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        chk("done_cleared", 64'(bus.done), 64'd0);
        if (poke_busy) begin
            @(posedge clk); #1;
            bus.start       = 1'b1;
            bus.wait_cycles = 16'd0;
            bus.exp_we      = 1'b1;
            bus.exp_idx     = 3'd0;
            bus.exp_reg     = 5'd31;
            bus.exp_val     = 32'hDEAD_BEEF;
            bus.exp_valid   = 1'b1;
            @(posedge clk); #1;
            bus.start  = 1'b0;
            bus.exp_we = 1'b0;
        end
        for (int i = 0; i < int'(w) + N + 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        chk("done_reached", 64'(exp_q.size()), 64'd0);
        chk("reads_all_issued", 64'(rd_q.size()), 64'd0);
        exp_q.delete();
        rd_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done_sticky", 64'(bus.done), 64'd1);
        chk("fail_count_hold", 64'(bus.fail_count), 64'(last_e.fcnt));
    endtask

    task automatic reset_and_check(input string tag);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        rd_q.delete();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_pass"}, 64'(bus.pass), 64'd0);
        chk({tag, "_rd_en"}, 64'(bus.rd_en), 64'd0);
        chk({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
        chk({tag, "_fail_count"}, 64'(bus.fail_count), 64'd0);
        chk({tag, "_ff_idx"}, 64'(bus.first_fail_idx), 64'd0);
        chk({tag, "_ff_val"}, 64'(bus.first_fail_val), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        abort_mode = 1'b0;
    endtask

    task automatic start_raw(input int unsigned w);
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.wait_cycles = 16'(w);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic load_basic();
        wr(0, 1, 32'd5, 1'b1);
        wr(1, 2, 32'd10, 1'b1);
        wr(2, 3, 32'd15, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.exp_we = 1'b0; bus.exp_idx = '0; bus.exp_reg = '0; bus.exp_val = '0;
        bus.exp_valid = 1'b0; bus.start = 1'b0; bus.wait_cycles = '0; bus.rd_data = '0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0; m_reg[i] = 0; m_val[i] = '0;
        end
        repeat (3) @(posedge clk);
        reset_and_check("reset");

        // Directed: matching table, one mismatch, two mismatches.
        rf[1] = 32'd5; rf[2] = 32'd10; rf[3] = 32'd15;
        load_basic();
        run_check(25, 1'b0);
        rf[2] = 32'd11;
        run_check(3, 1'b0);
        rf[1] = 32'd4; rf[2] = 32'd10; rf[3] = 32'd16;
        run_check(1, 1'b0);

        // No valid entries, no wait.
        for (int i = 0; i < 3; i++) wr(i, i + 1, 32'd0, 1'b0);
        run_check(0, 1'b0);

        // start/exp_we while busy must not disturb the scan or the table.
        rf[1] = 32'd5; rf[2] = 32'd10; rf[3] = 32'd15;
        load_basic();
        run_check(4, 1'b1);
        run_check(0, 1'b0);

        // Randomized tables, register contents and wait times.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) begin
                int unsigned rg = $urandom_range(0, 31);
                logic [DW-1:0] v = $urandom;
                bit vld = ($urandom_range(0, 3) != 0);
                wr(i, rg, v, vld);
                rf[rg] = v;
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0) rf[m_reg[i]] = rf[m_reg[i]] ^ (32'd1 << $urandom_range(0, 31));
            end
            run_check($urandom_range(0, 20), 1'b0);
        end

        // Reset while waiting and while scanning; table must come back empty.
        load_basic();
        abort_mode = 1'b1;
        start_raw(10);
        repeat (4) @(posedge clk);
        reset_and_check("rst_wait");
        load_basic();
        abort_mode = 1'b1;
        start_raw(2);
        repeat (4) @(posedge clk);
        reset_and_check("rst_scan");
        repeat (4) @(posedge clk);
        run_check(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
